// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory bus
module bus_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_byte_mark,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_byte_mark,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  stall,
  output logic                  err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [2:0]    STREAK_MAX = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [2:0]    d_streak;
  logic [WW-1:0] wait_cnt;
  logic          grant_i, grant_d, complete, expire;
  logic          arb_open, starved;

  // A port whose ack is showing has a request line that may still be the old
  // one, so arbitration waits out the ack cycle; this also lets a held D
  // request keep winning until the starvation guard hands the bus to I.
  assign arb_open = ~i_ack & ~d_ack;
  assign starved  = (d_streak == STREAK_MAX) & i_req;

  // Pipeline hold while either requester is still waiting for its ack.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: arbitration in IDLE, completion or timeout while granted.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_open) begin
          if (d_req && !starved) begin
            grant_d    = 1'b1;
            state_next = GNT_D;
          end else if (i_req) begin
            grant_i    = 1'b1;
            state_next = GNT_I;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (m_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus launch, response capture, ack/err pulses, streak and wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_byte_mark <= 4'b0000;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      err         <= 1'b0;
      d_streak    <= 3'd0;
      wait_cnt    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;

      if (grant_i) begin
        m_req       <= 1'b1;
        m_we        <= 1'b0;
        m_addr      <= i_addr;
        m_wdata     <= '0;
        m_byte_mark <= 4'b1111;
        wait_cnt    <= '0;
        d_streak    <= 3'd0;
      end

      if (grant_d) begin
        m_req       <= 1'b1;
        m_we        <= d_we;
        m_addr      <= d_addr;
        m_wdata     <= d_wdata;
        m_byte_mark <= d_byte_mark;
        wait_cnt    <= '0;
        // Only grants that actually made I wait count toward starvation.
        if (!i_req)                      d_streak <= 3'd0;
        else if (d_streak != STREAK_MAX) d_streak <= d_streak + 3'd1;
      end

      if (complete || expire) begin
        m_req <= 1'b0;
        err   <= expire;
        if (state == GNT_I) begin
          i_ack   <= 1'b1;
          i_rdata <= expire ? '0 : m_rdata;
        end else begin
          d_ack <= 1'b1;
          if (expire)     d_rdata <= '0;
          else if (!m_we) d_rdata <= m_rdata;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_mark;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byte_mark;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        stall;
  logic        err;

  bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_mark(d_byte_mark), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byte_mark(m_byte_mark), .m_rdata(m_rdata), .m_ready(m_ready),
    .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bm;
    logic [31:0] mrdata;
    int          dly;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  vec_t        vecs [6];
  exp_t        sb [$];
  logic        order_q [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_mreq(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_req && n < 20);
    chk({name, "_grant"}, m_req, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    exp_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_byte_mark = v.bm;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    wait_mreq(tag, n);
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_m_addr"}, m_addr, v.addr);
    chk({tag, "_m_we"}, m_we, v.is_d ? v.we : 1'b0);
    chk({tag, "_m_bm"}, m_byte_mark, v.is_d ? v.bm : 4'hF);
    if (v.is_d && v.we) chk({tag, "_m_wdata"}, m_wdata, v.wdata);
    chk({tag, "_stall_busy"}, stall, 1);
    repeat (v.dly) @(negedge clk);
    chk({tag, "_m_req_hold"}, m_req, 1);
    m_ready = 1;
    m_rdata = v.mrdata;
    if (v.is_d) begin
      if (!v.we) exp_d = v.mrdata;
      sb.push_back('{1'b1, exp_d});
    end else begin
      exp_i = v.mrdata;
      sb.push_back('{1'b0, exp_i});
    end
    @(negedge clk);
    m_ready = 0;
    m_rdata = $urandom;
    chk({tag, "_ack_port"}, {i_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
    e = sb.pop_front();
    chk({tag, "_rdata"}, e.is_d ? d_rdata : i_rdata, e.rdata);
    chk({tag, "_m_req_drop"}, m_req, 0);
    chk({tag, "_stall_done"}, stall, 0);
    i_req = 0;
    d_req = 0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, {i_ack, d_ack}, 2'b00);
  endtask

  initial begin
    int   n;
    logic got_d, want_d;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          4'h0, 32'h0050_0093, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,          4'hF, 32'h1122_3344, 0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D,  4'h3, 32'h9999_9999, 1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_2008, 32'h0,          4'hF, 32'h5566_7788, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,          4'h0, 32'h00A0_0113, 2};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_200C, 32'h0102_0304,  4'hC, 32'h7777_7777, 0};

    rst_n = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_byte_mark = '0; m_rdata = '0; m_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_bm", m_byte_mark, 0);
    chk("rst_acks", {i_ack, d_ack, err}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1;

    // m_ready while idle must be ignored
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    chk("idle_ready_no_ack", {i_ack, d_ack, m_req}, 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // simultaneous request: D write wins, then I
    i_req = 1; i_addr = 32'h0000_0600;
    d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_byte_mark = 4'b0011;
    wait_mreq("sim_d", n);
    chk("sim_d_addr", m_addr, 32'h0000_2000);
    chk("sim_d_we", m_we, 1);
    chk("sim_d_bm", m_byte_mark, 4'b0011);
    chk("sim_d_wdata", m_wdata, 32'hDEAD_BEEF);
    m_ready = 1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_ready = 0;
    chk("sim_d_ack", {i_ack, d_ack}, 2'b01);
    chk("sim_d_rdata_kept", d_rdata, exp_d);
    d_req = 0;
    wait_mreq("sim_i", n);
    chk("sim_i_addr", m_addr, 32'h0000_0600);
    chk("sim_i_we", m_we, 0);
    chk("sim_i_bm", m_byte_mark, 4'hF);
    m_ready = 1; m_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    m_ready = 0;
    chk("sim_i_ack", {i_ack, d_ack}, 2'b10);
    chk("sim_i_rdata", i_rdata, 32'h0BAD_F00D);
    exp_i = 32'h0BAD_F00D;
    i_req = 0;
    @(negedge clk);

    // starvation: both held, expected order D D D D I D
    order_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    i_req = 1; i_addr = 32'h0000_0100;
    d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
    for (int k = 0; k < 6; k++) begin
      wait_mreq($sformatf("starve%0d", k), n);
      got_d  = (m_addr == 32'h0000_2000);
      want_d = order_q.pop_front();
      chk($sformatf("starve_order%0d", k), got_d, want_d);
      m_ready = 1; m_rdata = 32'hA5A5_0000 + k;
      @(negedge clk);
      m_ready = 0;
    end
    i_req = 0; d_req = 0;
    chk("starve_last_rdata", d_rdata, 32'hA5A5_0005);
    @(negedge clk);

    // timeout on a D read
    d_req = 1; d_we = 0; d_addr = 32'h0000_3000;
    wait_mreq("tmo", n);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
      if (!err && n < 255 && !stall) chk("tmo_stall", stall, 1);
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_d_ack", d_ack, 1);
    chk("tmo_d_rdata", d_rdata, 0);
    chk("tmo_m_req", m_req, 0);
    d_req = 0;
    @(negedge clk);
    chk("tmo_pulse", {err, d_ack}, 0);
    chk("tmo_idle", m_req, 0);

    // reset in the middle of a fetch
    i_req = 1; i_addr = 32'h0000_0400;
    wait_mreq("rmid", n);
    rst_n = 0;
    #1;
    chk("rmid_m_req_async", m_req, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rmid_no_ack", {i_ack, err}, 0);
      chk("rmid_i_rdata", i_rdata, 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("rmid_first_arb", m_req, 1);
    chk("rmid_addr", m_addr, 32'h0000_0400);
    m_ready = 1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    m_ready = 0;
    chk("rmid_ack", i_ack, 1);
    chk("rmid_rdata", i_rdata, 32'h1234_5678);
    i_req = 0;
    @(negedge clk);

    // back-to-back fetches with i_req held across the ack
    i_req = 1; i_addr = 32'h0000_0500;
    wait_mreq("b2b1", n);
    m_ready = 1; m_rdata = 32'h0000_0001;
    @(negedge clk);
    m_ready = 0;
    chk("b2b_ack1", i_ack, 1);
    chk("b2b_no_same_cycle", m_req, 0);
    chk("b2b_stall_ack", stall, 0);
    @(negedge clk);
    chk("b2b_gap", m_req, 0);
    chk("b2b_stall_gap", stall, 1);
    @(negedge clk);
    chk("b2b_regrant", m_req, 1);
    m_ready = 1; m_rdata = 32'h0000_0002;
    @(negedge clk);
    m_ready = 0;
    chk("b2b_ack2", i_ack, 1);
    chk("b2b_rdata2", i_rdata, 32'h0000_0002);
    i_req = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, data/address width.
REQ-002 Parameter: STARVE_LIMIT, 4, max consecutive D grants while I waits.
REQ-003 Parameter: TIMEOUT, 255, max cycles waiting on m_ready.
REQ-004 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_req  in  1  instruction fetch request
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched instruction
- i_ack  out  1  fetch done, 1-cycle pulse
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_byte_mark  in  4  store byte enables
- d_rdata  out  32  load data
- d_ack  out  1  data done, 1-cycle pulse
- m_req  out  1  shared memory request
- m_we  out  1  shared memory write
- m_addr  out  32  shared memory address
- m_wdata  out  32  shared memory write data
- m_byte_mark  out  4  shared memory byte enables
- m_rdata  in  32  shared memory read data
- m_ready  in  1  shared memory completion
- stall  out  1  pipeline hold
- err  out  1  timeout pulse

Function
REQ-006 The FSM SHALL have states IDLE, GNT_I and GNT_D.
REQ-007 In IDLE, if d_req and the D port is eligible, the FSM SHALL enter GNT_D.
REQ-008 Otherwise, in IDLE, if i_req and the I port is eligible, the FSM SHALL enter GNT_I.
REQ-009 If d_streak equals STARVE_LIMIT and i_req is high, I SHALL win over D.
REQ-010 A port acked in the current cycle SHALL be ineligible in that same cycle.
REQ-011 On IDLE->GNT_x, m_addr, m_wdata, m_byte_mark and m_we SHALL be registered from port x, and m_req SHALL be 1 from the next cycle.
REQ-012 For GNT_I, m_we SHALL be 0 and m_byte_mark SHALL be 4'b1111.
REQ-013 m_* outputs SHALL hold stable while in GNT_x.
REQ-014 In GNT_x with m_ready=1:
- m_rdata SHALL be registered into x_rdata.
- x_ack SHALL be 1 in the next cycle only.
- m_req SHALL drop to 0.
- The FSM SHALL return to IDLE.
REQ-015 Minimum latency: request sampled at cycle 0, m_req at cycle 1, m_ready at cycle 1, x_ack at cycle 2.
REQ-016 x_rdata SHALL hold its value until the next completion on that port.
REQ-017 For writes, d_rdata SHALL be unchanged.
REQ-018 If x_req deasserts mid-transaction, the transaction SHALL still complete and x_ack SHALL still pulse.
REQ-019 d_streak (3 bits) SHALL increment on each D grant made while i_req=1, saturating at STARVE_LIMIT.
REQ-020 d_streak SHALL clear on every I grant.
REQ-021 d_streak SHALL clear on any D grant made while i_req=0.
REQ-022 A wait counter SHALL count cycles in GNT_x with m_ready=0.
REQ-023 When the wait counter reaches TIMEOUT:
- err SHALL pulse 1 cycle.
- x_rdata SHALL be set to 0.
- x_ack SHALL pulse.
- m_req SHALL drop.
- The FSM SHALL go to IDLE.
REQ-024 The wait counter SHALL clear on every grant.
REQ-025 stall SHALL be (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
REQ-026 m_ready while in IDLE SHALL be ignored.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE.
REQ-028 While rst_n=0, every registered output SHALL be 0: m_*, i_rdata, d_rdata, i_ack, d_ack, err.
REQ-029 While rst_n=0, d_streak and the wait counter SHALL be 0.
REQ-030 Reset during GNT_x SHALL abandon the transaction with no ack.
REQ-031 After reset release, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-032 The bench SHALL cover a lone fetch:
- Stimulus: i_req=1, i_addr=0x100, m_ready=1 at cycle 1, m_rdata=0x00500093.
- Response: i_ack at cycle 2, i_rdata=0x00500093, stall=0 from cycle 2.
REQ-033 The bench SHALL cover a simultaneous request:
- Stimulus: i_req and d_req both 1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_byte_mark=4'b0011.
- Response: D is granted first, with m_we=1 and m_byte_mark=4'b0011; d_ack; then I is granted.
REQ-034 The bench SHALL cover starvation:
- Stimulus: d_req and i_req held high continuously.
- Response: grant order is D,D,D,D,I,D...
REQ-035 The bench SHALL cover a timeout:
- Stimulus: d_req=1, m_ready held at 0.
- Response: err and d_ack pulse 255 cycles after the grant, d_rdata=0, FSM back to IDLE.
REQ-036 The bench SHALL cover reset mid-transaction:
- Stimulus: assert rst_n=0 while in GNT_I with m_req=1.
- Response: m_req=0 immediately, no i_ack, normal fetch after release.
REQ-037 The bench SHALL cover back-to-back fetches:
- Stimulus: i_req held high across an ack.
- Response: the second fetch is granted one cycle after the ack, never in the same cycle.
